// File: rtl/regfile32x8_onehot_if.sv
// Bus bundle between the 5-to-32 decoder stage and the register file:
// one-hot write port, two binary-addressed read ports, clear request and status.
interface regfile32x8_onehot_if #(
  parameter int WIDTH = 8
);
  logic             WE;
  logic [31:0]      WSEL;
  logic [WIDTH-1:0] WD;
  logic [4:0]       RA;
  logic [4:0]       RB;
  logic [WIDTH-1:0] DA;
  logic [WIDTH-1:0] DB;
  logic             CLR;
  logic             BUSY;
  logic             ERR;

  // Requester side: drives writes, read addresses and clear; observes data and status.
  modport master (
    output WE, WSEL, WD, RA, RB, CLR,
    input  DA, DB, BUSY, ERR
  );

  // Register file side.
  modport slave (
    input  WE, WSEL, WD, RA, RB, CLR,
    output DA, DB, BUSY, ERR
  );
endinterface

// File: rtl/regfile32x8_onehot.sv
// 32 x WIDTH register file fed by a one-hot write select.
// Two registered read ports with optional write-to-read forwarding, a
// one-entry-per-cycle clear sweep after reset or on request, and a sticky
// flag for write selects that are not exactly one-hot.
module regfile32x8_onehot #(
  parameter int WIDTH  = 8,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  regfile32x8_onehot_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [4:0] LAST_ENTRY = 5'd31;

  // True when exactly one bit of the select is set.
  function automatic logic onehot_ok(input logic [31:0] sel);
    return (sel != 32'd0) && ((sel & (sel - 32'd1)) == 32'd0);
  endfunction

  // OR-reduction encoder: bit b of the index is the OR of all select bits
  // whose position has bit b set. Meaningful only for a one-hot input.
  function automatic logic [4:0] onehot_index(input logic [31:0] sel);
    logic [4:0] idx;
    idx = 5'd0;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 32; i++) begin
        if (((i >> b) & 1) == 1) begin
          idx[b] = idx[b] | sel[i];
        end else begin
          idx[b] = idx[b];
        end
      end
    end
    return idx;
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] da_q, da_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] mem_q [32];
  logic [WIDTH-1:0] mem_d [32];

  logic             idle_s;
  logic             wr_req_s;
  logic             wsel_ok_s;
  logic             wr_en_s;
  logic [4:0]       widx_s;

  assign idle_s    = (state_q == IDLE);
  // A clear request in IDLE takes precedence over a coincident write.
  assign wr_req_s  = bus.WE & ~bus.CLR & idle_s;
  assign wsel_ok_s = onehot_ok(bus.WSEL);
  assign wr_en_s   = wr_req_s & wsel_ok_s;
  assign widx_s    = onehot_index(bus.WSEL);

  // Next-state logic for the sweep FSM, sweep counter and sticky error flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.CLR) begin
          state_d = SWEEP;
          cnt_d   = 5'd0;
          err_d   = 1'b0;
        end else if (bus.WE && !wsel_ok_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      SWEEP: begin
        if (bus.CLR) begin
          cnt_d = 5'd0;
          err_d = 1'b0;
        end else if (cnt_q == LAST_ENTRY) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = 5'd0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Array update: the sweep zeroes entry CNT; otherwise a valid write lands.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (state_q == SWEEP) begin
      mem_d[cnt_q] = {WIDTH{1'b0}};
    end else if (wr_en_s) begin
      mem_d[widx_s] = bus.WD;
    end else begin
      mem_d[0] = mem_q[0];
    end
  end

  // Read port A: array contents, overridden by this cycle's sweep or write when forwarding.
  always_comb begin
    da_d = mem_q[bus.RA];
    if (BYPASS && (state_q == SWEEP) && (cnt_q == bus.RA)) begin
      da_d = {WIDTH{1'b0}};
    end else if (BYPASS && wr_en_s && (widx_s == bus.RA)) begin
      da_d = bus.WD;
    end else begin
      da_d = mem_q[bus.RA];
    end
  end

  // Read port B: same rules as port A, evaluated independently.
  always_comb begin
    db_d = mem_q[bus.RB];
    if (BYPASS && (state_q == SWEEP) && (cnt_q == bus.RB)) begin
      db_d = {WIDTH{1'b0}};
    end else if (BYPASS && wr_en_s && (widx_s == bus.RB)) begin
      db_d = bus.WD;
    end else begin
      db_d = mem_q[bus.RB];
    end
  end

  // Control and read-data registers; reset launches a fresh sweep from entry 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SWEEP;
      cnt_q   <= 5'd0;
      err_q   <= 1'b0;
      da_q    <= {WIDTH{1'b0}};
      db_q    <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      da_q    <= da_d;
      db_q    <= db_d;
    end
  end

  // Storage array; no direct reset, the sweep after reset zeroes it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= mem_q[i];
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.DA   = da_q;
  assign bus.DB   = db_q;
  assign bus.BUSY = (state_q == SWEEP);
  assign bus.ERR  = err_q;

endmodule

// File: tb/tb_regfile32x8_onehot.sv
// Directed bench for regfile32x8_onehot. Two instances (forwarding on/off)
// share the same stimulus; a behavioural model predicts every output each
// cycle, and hand-computed literal checks pin the model at key points.
module tb_regfile32x8_onehot;

  logic        CLK = 1'b0;
  logic        RST;
  logic        we, clr;
  logic [31:0] wsel;
  logic [7:0]  wd;
  logic [4:0]  ra, rb;

  always #5 CLK = ~CLK;

  regfile32x8_onehot_if #(.WIDTH(8)) bus0 ();
  regfile32x8_onehot_if #(.WIDTH(8)) bus1 ();

  assign bus0.WE = we;   assign bus1.WE = we;
  assign bus0.WSEL = wsel; assign bus1.WSEL = wsel;
  assign bus0.WD = wd;   assign bus1.WD = wd;
  assign bus0.RA = ra;   assign bus1.RA = ra;
  assign bus0.RB = rb;   assign bus1.RB = rb;
  assign bus0.CLR = clr; assign bus1.CLR = clr;

  regfile32x8_onehot #(.WIDTH(8), .BYPASS(1'b0)) u_dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  regfile32x8_onehot #(.WIDTH(8), .BYPASS(1'b1)) u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [32];
  bit         m_known [32];
  bit         m_valid = 1'b0;
  bit         m_busy, m_err;
  int         m_cnt;
  logic [7:0] m_da [2];
  logic [7:0] m_db [2];
  bit         m_dak [2];
  bit         m_dbk [2];

  always @(posedge CLK) begin : model_b
    logic [7:0] a_val, b_val;
    bit         a_k, b_k;
    int         widx;
    if (RST) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b1;
      m_cnt   <= 0;
      m_err   <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_da[k] <= 8'h00; m_dak[k] <= 1'b1;
        m_db[k] <= 8'h00; m_dbk[k] <= 1'b1;
      end
    end else if (m_valid) begin
      a_val = m_mem[ra]; a_k = m_known[ra];
      b_val = m_mem[rb]; b_k = m_known[rb];
      for (int k = 0; k < 2; k++) begin
        m_da[k] <= a_val; m_dak[k] <= a_k;
        m_db[k] <= b_val; m_dbk[k] <= b_k;
      end
      if (m_busy) begin
        m_mem[m_cnt]   <= 8'h00;
        m_known[m_cnt] <= 1'b1;
        if (m_cnt == int'(ra)) begin m_da[1] <= 8'h00; m_dak[1] <= 1'b1; end
        if (m_cnt == int'(rb)) begin m_db[1] <= 8'h00; m_dbk[1] <= 1'b1; end
        if (clr) begin
          m_cnt <= 0; m_err <= 1'b0;
        end else if (m_cnt == 31) begin
          m_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (clr) begin
        m_busy <= 1'b1; m_cnt <= 0; m_err <= 1'b0;
      end else if (we) begin
        if ($countones(wsel) == 1) begin
          widx = 0;
          for (int i = 0; i < 32; i++) if (wsel[i]) widx = i;
          m_mem[widx]   <= wd;
          m_known[widx] <= 1'b1;
          if (widx == int'(ra)) begin m_da[1] <= wd; m_dak[1] <= 1'b1; end
          if (widx == int'(rb)) begin m_db[1] <= wd; m_dbk[1] <= 1'b1; end
        end else begin
          m_err <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("cmp_busy0", {31'd0, bus0.BUSY}, {31'd0, m_busy});
      chk("cmp_busy1", {31'd0, bus1.BUSY}, {31'd0, m_busy});
      chk("cmp_err0",  {31'd0, bus0.ERR},  {31'd0, m_err});
      chk("cmp_err1",  {31'd0, bus1.ERR},  {31'd0, m_err});
      if (m_dak[0]) chk("cmp_da0", {24'd0, bus0.DA}, {24'd0, m_da[0]});
      if (m_dbk[0]) chk("cmp_db0", {24'd0, bus0.DB}, {24'd0, m_db[0]});
      if (m_dak[1]) chk("cmp_da1", {24'd0, bus1.DA}, {24'd0, m_da[1]});
      if (m_dbk[1]) chk("cmp_db1", {24'd0, bus1.DB}, {24'd0, m_db[1]});
    end
  end

  // Count cycles until BUSY drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(posedge CLK);
      @(negedge CLK);
      n++;
    end while (bus1.BUSY && n < 100);
  endtask

  task automatic write1(input logic [31:0] sel, input logic [7:0] d);
    we = 1'b1; wsel = sel; wd = d;
    @(negedge CLK);
    we = 1'b0; wsel = 32'd0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    RST = 1'b1; we = 1'b0; clr = 1'b0; wsel = 32'd0; wd = 8'h00; ra = 5'd0; rb = 5'd0;

    // Reset release and initial sweep length
    @(negedge CLK); @(negedge CLK);
    chk("rst_da", {24'd0, bus1.DA}, 32'h0);
    chk("rst_err", {31'd0, bus1.ERR}, 32'h0);
    RST = 1'b0;
    chk("rst_busy", {31'd0, bus1.BUSY}, 32'h1);
    wait_idle(n);
    chk("rst_busy_len", n, 32);

    // Whole array reads zero after the sweep
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i);
      @(negedge CLK);
      chk("zero_da", {24'd0, bus1.DA}, 32'h0);
      chk("zero_db", {24'd0, bus0.DB}, 32'h0);
    end

    // Basic write / read
    write1(32'h0000_0020, 8'hA5);
    ra = 5'd5; rb = 5'd4;
    @(negedge CLK);
    chk("wr_da", {24'd0, bus1.DA}, 32'hA5);
    chk("wr_db", {24'd0, bus1.DB}, 32'h00);

    // Forwarding on entry 31
    ra = 5'd31; rb = 5'd31;
    write1(32'h8000_0000, 8'h3C);
    chk("byp1_da", {24'd0, bus1.DA}, 32'h3C);
    chk("byp1_db", {24'd0, bus1.DB}, 32'h3C);
    chk("byp0_da", {24'd0, bus0.DA}, 32'h00);
    chk("byp0_db", {24'd0, bus0.DB}, 32'h00);
    @(negedge CLK);
    chk("byp0_da_late", {24'd0, bus0.DA}, 32'h3C);

    // One-hot violations
    write1(32'h0000_0001, 8'h11);
    write1(32'h0000_0002, 8'h22);
    wsel = 32'h0000_0003;
    @(negedge CLK);
    chk("we0_no_err", {31'd0, bus1.ERR}, 32'h0);
    write1(32'h0000_0003, 8'hFF);
    chk("multi_err", {31'd0, bus1.ERR}, 32'h1);
    ra = 5'd0; rb = 5'd1;
    @(negedge CLK);
    chk("multi_e0", {24'd0, bus1.DA}, 32'h11);
    chk("multi_e1", {24'd0, bus1.DB}, 32'h22);
    write1(32'h0000_0000, 8'h5A);
    chk("zero_sel_err", {31'd0, bus1.ERR}, 32'h1);
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
    chk("clr_err", {31'd0, bus1.ERR}, 32'h0);
    chk("clr_busy", {31'd0, bus1.BUSY}, 32'h1);
    wait_idle(n);
    chk("clr_busy_len", n, 32);

    // Write during sweep is dropped
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
    write1(32'h0000_0001, 8'h77);
    chk("sweep_wr_err", {31'd0, bus1.ERR}, 32'h0);
    wait_idle(n);
    ra = 5'd0;
    @(negedge CLK);
    chk("sweep_wr_e0", {24'd0, bus1.DA}, 32'h00);

    // Clear and write together in IDLE: clear wins
    write1(32'h0000_0004, 8'h55);
    ra = 5'd2;
    we = 1'b1; wsel = 32'h0000_0004; wd = 8'h99; clr = 1'b1;
    @(negedge CLK);
    we = 1'b0; wsel = 32'd0; clr = 1'b0;
    chk("clrwr_err", {31'd0, bus1.ERR}, 32'h0);
    chk("clrwr_busy", {31'd0, bus1.BUSY}, 32'h1);
    chk("clrwr_nobyp", {24'd0, bus1.DA}, 32'h55);
    wait_idle(n);
    @(negedge CLK);
    chk("clrwr_e2", {24'd0, bus1.DA}, 32'h00);

    // Sweep restart by a second clear at sweep cycle 10
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
    repeat (10) @(negedge CLK);
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
    wait_idle(n);
    chk("restart_len", n, 32);

    // Reset at sweep cycle 5
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    wait_idle(n);
    chk("rst_mid_len", n, 32);
    @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
